// File: rtl/rf_access_pkg.sv
// Shared types and width helpers for the variable access engine and its descriptor table.
package rf_access_pkg;

    function automatic int rf_id_w(input int num_vars);
        return (num_vars > 1) ? $clog2(num_vars) : 1;
    endfunction

    function automatic int rf_ofs_w(input int store_bits);
        return (store_bits > 1) ? $clog2(store_bits) : 1;
    endfunction

    function automatic int rf_wid_w(input int max_var_w);
        return $clog2(max_var_w + 1);
    endfunction

    // Fields are wide enough for any legal geometry so bound arithmetic never wraps.
    typedef struct packed {
        logic        valid;
        logic [31:0] offset;
        logic [31:0] width;
    } rf_descriptor_t;

    typedef enum logic [1:0] {
        RF_IDLE   = 2'd0,
        RF_LOOKUP = 2'd1,
        RF_ACCESS = 2'd2,
        RF_RESP   = 2'd3
    } rf_state_e;

endpackage

// File: rtl/rf_descriptor_table.sv
// Handle -> {offset, width} register file: one write port, one combinational read port.
module rf_descriptor_table
    import rf_access_pkg::*;
#(
    parameter int NUM_VARS  = 16,
    parameter int MAX_VAR_W = 128,
    parameter int ID_W      = 4,
    parameter int OFS_W     = 11,
    parameter int WID_W     = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             we,
    input  logic [ID_W-1:0]  wr_id,
    input  logic [OFS_W-1:0] wr_offset,
    input  logic [WID_W-1:0] wr_width,
    input  logic [ID_W-1:0]  rd_id,
    output rf_descriptor_t   rd_desc
);

    logic [NUM_VARS-1:0] valid_q;
    logic [NUM_VARS-1:0] wr_sel;
    logic [OFS_W-1:0]    offset_q [NUM_VARS];
    logic [WID_W-1:0]    width_q  [NUM_VARS];
    logic [WID_W-1:0]    wr_width_clamped;

    assign wr_width_clamped = (32'(wr_width) > 32'(MAX_VAR_W)) ? WID_W'(MAX_VAR_W) : wr_width;

    generate
        for (genvar gi = 0; gi < NUM_VARS; gi++) begin : g_sel
            assign wr_sel[gi] = we && (wr_id == ID_W'(gi));
        end
    endgenerate

    // A zero width retires the handle; only the valid bits need reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
        end else begin
            for (int i = 0; i < NUM_VARS; i++) begin
                if (wr_sel[i]) valid_q[i] <= (wr_width != '0);
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_VARS; i++) begin
            if (wr_sel[i]) begin
                offset_q[i] <= wr_offset;
                width_q[i]  <= wr_width_clamped;
            end
        end
    end

    always_comb begin
        rd_desc = '0;
        if (32'(rd_id) < 32'(NUM_VARS)) begin
            rd_desc.valid  = valid_q[rd_id];
            rd_desc.offset = 32'(offset_q[rd_id]);
            rd_desc.width  = 32'(width_q[rd_id]);
        end
    end

endmodule

// File: rtl/rf_variable_access_engine.sv
// Reads/writes arbitrary-width variables in a packed word store by handle, one store word per cycle.
module rf_variable_access_engine
    import rf_access_pkg::*;
#(
    parameter  int DATA_W      = 32,
    parameter  int STORE_WORDS = 64,
    parameter  int NUM_VARS    = 16,
    parameter  int MAX_VAR_W   = 128,
    localparam int ID_W        = rf_id_w(NUM_VARS),
    localparam int OFS_W       = rf_ofs_w(STORE_WORDS * DATA_W),
    localparam int WID_W       = rf_wid_w(MAX_VAR_W)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 cfg_we,
    output logic                 cfg_ready,
    input  logic [ID_W-1:0]      cfg_id,
    input  logic [OFS_W-1:0]     cfg_offset,
    input  logic [WID_W-1:0]     cfg_width,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_write,
    input  logic [ID_W-1:0]      req_id,
    input  logic [MAX_VAR_W-1:0] req_wdata,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [MAX_VAR_W-1:0] rsp_rdata,
    output logic                 rsp_err
);

    localparam int STORE_BITS = STORE_WORDS * DATA_W;
    localparam int WI_W       = (STORE_WORDS > 1) ? $clog2(STORE_WORDS) : 1;
    localparam int FI_W       = (MAX_VAR_W > 1) ? $clog2(MAX_VAR_W) : 1;

    localparam logic [1:0] S_IDLE   = 2'(RF_IDLE);
    localparam logic [1:0] S_LOOKUP = 2'(RF_LOOKUP);
    localparam logic [1:0] S_ACCESS = 2'(RF_ACCESS);
    localparam logic [1:0] S_RESP   = 2'(RF_RESP);

    logic [1:0]           state_q, state_d;
    logic                 phase_q, phase_d;
    logic                 write_q, write_d;
    logic                 err_q, err_d;
    logic [ID_W-1:0]      id_q, id_d;
    logic [MAX_VAR_W-1:0] wdata_q, wdata_d;
    logic [MAX_VAR_W-1:0] rdata_q, rdata_d;
    rf_descriptor_t       desc_q, desc_d, tbl_desc;
    logic [WI_W-1:0]      w0_q, w0_d;
    logic [WI_W:0]        nw_q, nw_d, cnt_q, cnt_d, cnt_inc;

    logic [DATA_W-1:0]    store_q [STORE_WORDS];
    logic [WI_W-1:0]      cur_idx;
    logic [DATA_W-1:0]    cur_word, word_nxt;
    logic [31:0]          word_base, fld_end, first_w, last_w;
    logic                 lookup_bad;
    logic [DATA_W-1:0]    in_fld;
    logic [FI_W-1:0]      f_idx [DATA_W];

    rf_descriptor_table #(
        .NUM_VARS (NUM_VARS),
        .MAX_VAR_W(MAX_VAR_W),
        .ID_W     (ID_W),
        .OFS_W    (OFS_W),
        .WID_W    (WID_W)
    ) u_desc_table (
        .clk      (clk),
        .rst_n    (rst_n),
        .we       (cfg_we && cfg_ready),
        .wr_id    (cfg_id),
        .wr_offset(cfg_offset),
        .wr_width (cfg_width),
        .rd_id    (id_q),
        .rd_desc  (tbl_desc)
    );

    assign cfg_ready = (state_q == S_IDLE);
    assign req_ready = (state_q == S_IDLE) && !cfg_we;
    assign rsp_valid = (state_q == S_RESP);
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;

    // Descriptor is registered in the first LOOKUP cycle, the bound check runs in the second.
    assign fld_end    = desc_q.offset + desc_q.width;
    assign lookup_bad = !desc_q.valid || (fld_end > 32'(STORE_BITS));
    assign first_w    = desc_q.offset / 32'(DATA_W);
    assign last_w     = (fld_end - 32'd1) / 32'(DATA_W);

    assign cnt_inc   = cnt_q + (WI_W + 1)'(1);
    assign cur_idx   = w0_q + WI_W'(cnt_q);
    assign cur_word  = store_q[cur_idx];
    assign word_base = 32'(cur_idx) * 32'(DATA_W);

    // Per store bit: is it inside the field, and which field bit does it carry.
    generate
        for (genvar gi = 0; gi < DATA_W; gi++) begin : g_bit
            logic [31:0] bit_pos;
            assign bit_pos     = word_base + 32'(gi);
            assign in_fld[gi]  = (bit_pos >= desc_q.offset) && (bit_pos < fld_end);
            assign f_idx[gi]   = FI_W'(bit_pos - desc_q.offset);
        end
    endgenerate

    always_comb begin
        state_d  = state_q;
        phase_d  = phase_q;
        write_d  = write_q;
        err_d    = err_q;
        id_d     = id_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        desc_d   = desc_q;
        w0_d     = w0_q;
        nw_d     = nw_q;
        cnt_d    = cnt_q;
        word_nxt = cur_word;
        case (state_q)
            S_IDLE: begin
                if (req_valid && req_ready) begin
                    state_d = S_LOOKUP;
                    phase_d = 1'b0;
                    write_d = req_write;
                    id_d    = req_id;
                    wdata_d = req_wdata;
                    rdata_d = '0;
                    err_d   = 1'b0;
                end
            end
            S_LOOKUP: begin
                if (!phase_q) begin
                    desc_d  = tbl_desc;
                    phase_d = 1'b1;
                end else if (lookup_bad) begin
                    err_d   = 1'b1;
                    state_d = S_RESP;
                end else begin
                    w0_d    = WI_W'(first_w);
                    nw_d    = (WI_W + 1)'(last_w - first_w + 32'd1);
                    cnt_d   = '0;
                    state_d = S_ACCESS;
                end
            end
            S_ACCESS: begin
                for (int b = 0; b < DATA_W; b++) begin
                    if (in_fld[b]) begin
                        rdata_d[f_idx[b]] = cur_word[b];
                        if (write_q) word_nxt[b] = wdata_q[f_idx[b]];
                    end
                end
                cnt_d = cnt_inc;
                if (cnt_inc == nw_q) state_d = S_RESP;
            end
            S_RESP: begin
                if (rsp_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            phase_q <= 1'b0;
            write_q <= 1'b0;
            err_q   <= 1'b0;
            id_q    <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            desc_q  <= '0;
            w0_q    <= '0;
            nw_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            write_q <= write_d;
            err_q   <= err_d;
            id_q    <= id_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            desc_q  <= desc_d;
            w0_q    <= w0_d;
            nw_q    <= nw_d;
            cnt_q   <= cnt_d;
        end
    end

    // Reset clears the whole store, which also discards a half-finished write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < STORE_WORDS; i++) store_q[i] <= '0;
        end else if (state_q == S_ACCESS && write_q) begin
            store_q[cur_idx] <= word_nxt;
        end
    end

endmodule

// File: tb/tb_rf_variable_access_engine.sv
// Directed vector table, collision/stall/reset sequences and a randomized run against a bit-array model.
module tb_rf_variable_access_engine;

    localparam int STORE_BITS = 2048;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         cfg_we = 1'b0;
    logic         cfg_ready;
    logic [3:0]   cfg_id = '0;
    logic [10:0]  cfg_offset = '0;
    logic [7:0]   cfg_width = '0;
    logic         req_valid = 1'b0;
    logic         req_ready;
    logic         req_write = 1'b0;
    logic [3:0]   req_id = '0;
    logic [127:0] req_wdata = '0;
    logic         rsp_valid;
    logic         rsp_ready = 1'b0;
    logic [127:0] rsp_rdata;
    logic         rsp_err;

    int checks = 0;
    int errors = 0;

    logic [STORE_BITS-1:0] m_mem;
    bit                    m_val [16];
    int                    m_ofs [16];
    int                    m_wid [16];

    typedef struct {
        bit           is_cfg;
        bit           wr;
        int           id;
        int           ofs;
        int           wid;
        logic [127:0] wd;
        logic [127:0] rd;
        bit           err;
        int           lat;
        int           hold;
    } vec_t;

    vec_t vecs[$];

    rf_variable_access_engine #(
        .DATA_W(32), .STORE_WORDS(64), .NUM_VARS(16), .MAX_VAR_W(128)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .cfg_we(cfg_we), .cfg_ready(cfg_ready), .cfg_id(cfg_id),
        .cfg_offset(cfg_offset), .cfg_width(cfg_width),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_id(req_id), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not reach its end");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic model_reset();
        m_mem = '0;
        for (int i = 0; i < 16; i++) m_val[i] = 1'b0;
    endtask

    task automatic model_cfg(input int id, input int ofs, input int wid);
        m_val[id] = (wid != 0);
        m_ofs[id] = ofs;
        m_wid[id] = (wid > 128) ? 128 : wid;
    endtask

    // Field = bits [ofs, ofs+wid) of one flat bit string; latency = 2 + words touched.
    task automatic model_access(input bit wr, input int id, input logic [127:0] wd,
                                output logic [127:0] rd, output bit err, output int lat);
        rd  = '0;
        err = 1'b0;
        lat = 2;
        if (!m_val[id] || (m_ofs[id] + m_wid[id] > STORE_BITS)) begin
            err = 1'b1;
        end else begin
            for (int i = 0; i < m_wid[id]; i++) begin
                rd[i] = m_mem[m_ofs[id] + i];
                if (wr) m_mem[m_ofs[id] + i] = wd[i];
            end
            lat = 2 + (m_ofs[id] + m_wid[id] - 1) / 32 - m_ofs[id] / 32 + 1;
        end
    endtask

    task automatic do_cfg(input int id, input int ofs, input int wid);
        @(negedge clk);
        chk("cfg_ready idle", cfg_ready, 1);
        cfg_we = 1'b1; cfg_id = id[3:0]; cfg_offset = ofs[10:0]; cfg_width = wid[7:0];
        @(posedge clk);
        model_cfg(id, ofs, wid);
        @(negedge clk);
        cfg_we = 1'b0;
        $display("cfg   id=%0d offset=%0d width=%0d", id, ofs, wid);
    endtask

    task automatic do_access(input string name, input bit sync, input bit wr, input int id,
                             input logic [127:0] wd, input int hold,
                             input logic [127:0] exp_rd, input bit exp_err, input int exp_lat);
        int n;
        int lat;
        if (sync) @(negedge clk);
        req_valid = 1'b1; req_write = wr; req_id = id[3:0]; req_wdata = wd;
        n = 0;
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            chk({name, " accept timeout"}, req_ready, 1);
            req_valid = 1'b0;
            return;
        end
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        lat = 0;
        while (!rsp_valid && lat < 100) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        chk({name, " rsp_valid"}, rsp_valid, 1);
        chk({name, " latency"}, lat, exp_lat);
        chk({name, " rdata"}, rsp_rdata, exp_rd);
        chk({name, " err"}, rsp_err, exp_err);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            @(negedge clk);
            chk({name, " hold rsp_valid"}, rsp_valid, 1);
            chk({name, " hold rdata"}, rsp_rdata, exp_rd);
            chk({name, " hold req_ready"}, req_ready, 0);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 1'b0;
        chk({name, " back to idle"}, req_ready, 1);
        $display("txn   %s %s id=%0d wdata=0x%0h rdata=0x%0h err=%0b lat=%0d",
                 name, wr ? "WR" : "RD", id, wd, rsp_rdata, rsp_err, lat);
    endtask

    initial begin
        logic [127:0] erd;
        bit           eerr;
        int           elat;

        vecs.push_back('{1, 0, 3, 28, 8, '0, '0, 0, 0, 0});
        vecs.push_back('{0, 1, 3, 0, 0, 128'hA5, 128'h0, 0, 4, 0});
        vecs.push_back('{1, 0, 2, 0, 64, '0, '0, 0, 0, 0});
        vecs.push_back('{0, 0, 2, 0, 0, '0, 128'h0000000A_50000000, 0, 4, 0});
        vecs.push_back('{0, 0, 3, 0, 0, '0, 128'hA5, 0, 4, 0});
        vecs.push_back('{0, 1, 3, 0, 0, 128'h1FF, 128'hA5, 0, 4, 0});
        vecs.push_back('{0, 0, 3, 0, 0, '0, 128'hFF, 0, 4, 0});
        vecs.push_back('{0, 0, 5, 0, 0, '0, 128'h0, 1, 2, 0});
        vecs.push_back('{1, 0, 0, 2040, 16, '0, '0, 0, 0, 0});
        vecs.push_back('{0, 0, 0, 0, 0, '0, 128'h0, 1, 2, 0});
        vecs.push_back('{1, 0, 1, 0, 128, '0, '0, 0, 0, 0});
        vecs.push_back('{0, 1, 1, 0, 0, 128'h01234567_89ABCDEF_FEDCBA98_76543210,
                         128'hF_F000_0000, 0, 6, 0});
        vecs.push_back('{0, 0, 1, 0, 0, '0, 128'h01234567_89ABCDEF_FEDCBA98_76543210, 0, 6, 5});
        vecs.push_back('{0, 0, 3, 0, 0, '0, 128'h87, 0, 4, 0});
        vecs.push_back('{0, 0, 2, 0, 0, '0, 128'hFEDCBA98_76543210, 0, 4, 0});
        vecs.push_back('{1, 0, 4, 1900, 200, '0, '0, 0, 0, 0});
        vecs.push_back('{0, 1, 4, 0, 0, {128{1'b1}}, 128'h0, 0, 7, 0});
        vecs.push_back('{0, 0, 4, 0, 0, '0, {128{1'b1}}, 0, 7, 0});
        vecs.push_back('{1, 0, 7, 1920, 128, '0, '0, 0, 0, 0});
        vecs.push_back('{0, 0, 7, 0, 0, '0, 128'h0000_0fff_ffff_ffff_ffff_ffff_ffff_ffff, 0, 6, 0});
        vecs.push_back('{1, 0, 4, 1900, 0, '0, '0, 0, 0, 0});
        vecs.push_back('{0, 0, 4, 0, 0, '0, 128'h0, 1, 2, 0});

        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("reset req_ready", req_ready, 1);
        chk("reset cfg_ready", cfg_ready, 1);
        chk("reset rsp_valid", rsp_valid, 0);
        chk("reset rsp_rdata", rsp_rdata, 0);
        chk("reset rsp_err", rsp_err, 0);

        foreach (vecs[i]) begin
            if (vecs[i].is_cfg) begin
                do_cfg(vecs[i].id, vecs[i].ofs, vecs[i].wid);
            end else begin
                model_access(vecs[i].wr, vecs[i].id, vecs[i].wd, erd, eerr, elat);
                do_access($sformatf("vec%0d", i), 1, vecs[i].wr, vecs[i].id, vecs[i].wd,
                          vecs[i].hold, vecs[i].rd, vecs[i].err, vecs[i].lat);
            end
        end

        // cfg and request in the same IDLE cycle: cfg is taken, request waits one cycle.
        @(negedge clk);
        cfg_we = 1'b1; cfg_id = 4'd6; cfg_offset = 11'd100; cfg_width = 8'd12;
        req_valid = 1'b1; req_write = 1'b0; req_id = 4'd6; req_wdata = '0;
        #1;
        chk("collide req_ready low", req_ready, 0);
        chk("collide cfg_ready", cfg_ready, 1);
        @(posedge clk);
        model_cfg(6, 100, 12);
        @(negedge clk);
        cfg_we = 1'b0;
        #1;
        chk("collide req_ready next", req_ready, 1);
        model_access(0, 6, '0, erd, eerr, elat);
        do_access("collide", 0, 0, 6, '0, 0, erd, eerr, elat);

        // Asynchronous reset in the middle of a 4-word write.
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; req_id = 4'd1; req_wdata = {128{1'b1}};
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midreset rsp_valid", rsp_valid, 0);
        chk("midreset rsp_rdata", rsp_rdata, 0);
        chk("midreset rsp_err", rsp_err, 0);
        chk("midreset req_ready", req_ready, 1);
        chk("midreset cfg_ready", cfg_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        do_access("post-reset id1", 1, 0, 1, '0, 0, 128'h0, 1, 2);
        do_access("post-reset id3", 1, 0, 3, '0, 0, 128'h0, 1, 2);
        do_cfg(2, 0, 64);
        model_access(0, 2, '0, erd, eerr, elat);
        do_access("post-reset store", 1, 0, 2, '0, 0, erd, eerr, elat);

        for (int k = 0; k < 12; k++) begin
            do_cfg($urandom_range(0, 15), $urandom_range(0, 2047),
                   ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 200));
        end
        for (int k = 0; k < 80; k++) begin
            int           id;
            bit           wr;
            int           hold;
            logic [127:0] wd;
            if ($urandom_range(0, 9) == 0) begin
                do_cfg($urandom_range(0, 15), $urandom_range(0, 2047),
                       ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 200));
            end
            id   = $urandom_range(0, 15);
            wr   = 1'($urandom_range(0, 1));
            hold = $urandom_range(0, 2);
            wd   = {$urandom, $urandom, $urandom, $urandom};
            model_access(wr, id, wd, erd, eerr, elat);
            do_access($sformatf("rand%0d", k), 1, wr, id, wd, hold, erd, eerr, elat);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
